ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single CPU RAM port between two requesters: the instruction-fetch port (read-only) and the MEM-stage data port (byte-lane read/write).
- Registers every RAM transaction and holds it until the RAM completes it.
- Returns read data and a one-cycle ready pulse to the requester that owns the transaction.
- Drives a pipeline stall request while any accepted request is still outstanding.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses (byte-select width is DATA_WIDTH/8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low
inst_req  in  1  fetch request, held until inst_ready
inst_addr  in  ADDR_WIDTH  fetch address, stable while inst_req
inst_ready  out  1  one-cycle completion pulse for fetch
inst_rdata  out  DATA_WIDTH  fetched word, valid when inst_ready
data_req  in  1  data request, held until data_ready
data_we  in  1  1=write, 0=read
data_sel  in  DATA_WIDTH/8  byte-lane write select
data_addr  in  ADDR_WIDTH  data address
data_wdata  in  DATA_WIDTH  write data (already lane-aligned)
data_ready  out  1  one-cycle completion pulse for data
data_rdata  out  DATA_WIDTH  read word, valid when data_ready after a read
ram_en  out  1  RAM transaction active
ram_write_en  out  1  RAM write strobe
ram_write_sel  out  DATA_WIDTH/8  RAM byte lanes
ram_addr  out  ADDR_WIDTH  RAM address
ram_write_data  out  DATA_WIDTH  RAM write data
ram_ready  in  1  RAM completes the current transaction this cycle
ram_read_data  in  DATA_WIDTH  RAM read data, valid with ram_ready
stall_req  out  1  pipeline stall request

Behaviour:
- FSM states: IDLE, GNT_DATA, GNT_INST, DONE. Reset state is IDLE.
- IDLE:
  - If data_req is high, latch the data fields into the ram_* output registers and go to GNT_DATA.
  - Else if inst_req is high, latch inst_addr (write_en=0, sel=0, wdata=0) and go to GNT_INST.
  - With no request, stay in IDLE.
  - Fixed priority: data beats instruction.
- GNT_DATA / GNT_INST:
  - ram_en=1 and all latched ram_* outputs are held constant.
  - The state is kept until ram_ready=1. There is no timeout.
  - On ram_ready:
    - For a read, capture ram_read_data into the owner's rdata register.
    - For a write, the owner's rdata keeps its previous value.
    - Set the owner's ready register; go to DONE.
- DONE:
  - Exactly one cycle. The owner's ready=1, ram_en=0, and all ram_* outputs are 0.
  - Requests are not sampled in DONE.
  - Next state is IDLE.
- Outputs while not in a GNT state: ram_en, ram_write_en, ram_write_sel, ram_addr and ram_write_data are all 0.
- ram_write_en is 1 only in GNT_DATA with a latched data_we=1.
- A write with data_sel=0 is still issued and completed normally.
- Latency: request seen in IDLE at cycle 0 → ram_en=1 from cycle 1. With ram_ready asserted at cycle k (k≥1), ready=1 at cycle k+1. Minimum request-to-ready is 2 cycles.
- Back-to-back: the next request is arbitrated in the cycle after DONE.
  - Minimum issue rate is 1 transaction per 3 cycles.
  - A requester that keeps req high after its ready pulse starts a new transaction.
- Starvation: under fixed priority, a continuous data stream starves fetch. This is accepted, because the MEM stage stalls fetch anyway.
- ram_ready outside the GNT states is ignored.
- inst_ready and data_ready are never high in the same cycle.
- stall_req is combinational: (data_req & ~data_ready) | (inst_req & ~inst_ready).
- Reset values: all outputs 0, inst_rdata=0, data_rdata=0, state IDLE.
- Reset asserted mid-transaction:
  - ram_en drops asynchronously and the transaction is abandoned.
  - No ready pulse is produced.
  - After release, operation restarts from IDLE.

Optional Feature:
RAM_ARB_RR_EN
- Defined: round-robin arbitration.
  - A last_grant register (reset value = instruction) records the owner of the last granted transaction.
  - When both requests are present in IDLE, grant the requester that was not last granted.
  - A single request is granted immediately.
- Undefined: fixed data-over-instruction priority; the last_grant register is not built.

Test Plan:
- Fetch only: inst_req=1, inst_addr=0x0000_0040; RAM returns ram_ready=1 on the first ram_en cycle with 0x2402_0005 → ram_addr=0x40 at cycle 1; inst_ready=1 with inst_rdata=0x2402_0005 at cycle 2; stall_req=1 for cycles 0-1.
- Byte write with wait states: data_req=1, data_we=1, data_sel=4'b0100, data_addr=0x100, data_wdata=0x5A5A_5A5A; ram_ready delayed 3 cycles → ram_* fields held constant for 3 cycles; ram_write_sel=4'b0100; one data_ready pulse; data_rdata unchanged.
- Simultaneous requests, both hold req:
  - Macro undefined → grant order data, data, ... (fetch starved while data_req stays high).
  - Macro defined → data, inst, data, inst.
- Data read with ram_read_data=0xDEAD_BEEF, then fetch queued behind it → data_ready and data_rdata=0xDEAD_BEEF first; fetch ram_en rises two cycles later; ready pulses never overlap.
- Reset mid-transaction: assert rst=0 while in GNT_INST → ram_en=0 immediately; no inst_ready; after release with inst_req still high, the fetch reissues from IDLE.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between the fetch and MEM data requesters.
// Define RAM_ARB_RR_EN for round-robin arbitration instead of fixed data-over-fetch priority.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_req,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_sel,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    ram_en,
    output logic                    ram_write_en,
    output logic [DATA_WIDTH/8-1:0] ram_write_sel,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic                    ram_ready,
    input  logic [DATA_WIDTH-1:0]   ram_read_data,
    output logic                    stall_req
);
    typedef enum logic [1:0] {IDLE, GNT_DATA, GNT_INST, DONE} state_t;
    state_t state;
    logic   pick_data;
    logic   any_req;
    logic   finish;
`ifdef RAM_ARB_RR_EN
    logic   last_inst;
    assign pick_data = data_req & (~inst_req | last_inst);
`else
    assign pick_data = data_req;
`endif
    assign any_req   = data_req | inst_req;
    assign finish    = (state == GNT_DATA || state == GNT_INST) && ram_ready;
    assign stall_req = (data_req & ~data_ready) | (inst_req & ~inst_ready);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ram_en         <= 1'b0;
            ram_write_en   <= 1'b0;
            ram_write_sel  <= '0;
            ram_addr       <= '0;
            ram_write_data <= '0;
            inst_ready     <= 1'b0;
            data_ready     <= 1'b0;
            inst_rdata     <= '0;
            data_rdata     <= '0;
`ifdef RAM_ARB_RR_EN
            last_inst      <= 1'b1;
`endif
        end else begin
            inst_ready <= 1'b0;
            data_ready <= 1'b0;
            case (state)
                IDLE: if (any_req) begin
                    ram_en         <= 1'b1;
                    ram_write_en   <= pick_data & data_we;
                    ram_write_sel  <= pick_data ? data_sel : '0;
                    ram_addr       <= pick_data ? data_addr : inst_addr;
                    ram_write_data <= pick_data ? data_wdata : '0;
                    state          <= pick_data ? GNT_DATA : GNT_INST;
`ifdef RAM_ARB_RR_EN
                    last_inst      <= ~pick_data;
`endif
                end
                GNT_DATA: if (ram_ready) begin
                    if (!ram_write_en) data_rdata <= ram_read_data;
                    data_ready <= 1'b1;
                    state      <= DONE;
                end
                GNT_INST: if (ram_ready) begin
                    inst_rdata <= ram_read_data;
                    inst_ready <= 1'b1;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
            // the RAM port is idle from the completing edge onward
            if (finish) begin
                ram_en         <= 1'b0;
                ram_write_en   <= 1'b0;
                ram_write_sel  <= '0;
                ram_addr       <= '0;
                ram_write_data <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a wait-state RAM model.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_sel = '0;
    logic        inst_ready, data_ready, ram_en, ram_write_en, ram_ready, stall_req;
    logic [31:0] inst_rdata, data_rdata, ram_addr, ram_write_data, ram_read_data;
    logic [3:0]  ram_write_sel;
    int          en_cnt = 0, ram_wait = 0, checks = 0, passes = 0;
    logic        poke = 1'b0, en_q = 1'b0;
    logic [31:0] exp_inst[$], exp_data[$], grants[$];
    logic [31:0] last_drd = '0;
    logic [31:0] g_exp [4];

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_sel(data_sel), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
        .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_write_sel(ram_write_sel),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_ready(ram_ready),
        .ram_read_data(ram_read_data), .stall_req(stall_req)
    );

    function automatic logic [31:0] rword(input logic [31:0] a);
        return a == 32'h40 ? 32'h2402_0005 : a == 32'h300 ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // RAM answers after ram_wait extra cycles of ram_en; poke injects a stray ready
    always @(posedge clk) en_cnt <= ram_en ? en_cnt + 1 : 0;
    assign ram_ready     = (ram_en && en_cnt == ram_wait) || poke;
    assign ram_read_data = rword(ram_addr);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        en_q <= ram_en;
        if (ram_en && !en_q) grants.push_back(ram_addr);
        if (inst_ready || data_ready) check("ready_excl", inst_ready & data_ready, 0);
        if (inst_ready) begin
            if (exp_inst.size() == 0) check("inst_unexp", inst_ready, 0);
            else check("sb_inst_rdata", inst_rdata, exp_inst.pop_front());
        end
        if (data_ready) begin
            if (exp_data.size() == 0) check("data_unexp", data_ready, 0);
            else check("sb_data_rdata", data_rdata, exp_data.pop_front());
        end
    end

    task automatic wait_rdy(input bit dsel, input int budget, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(dsel ? data_ready : inst_ready) && n < budget);
        check(tag, dsel ? data_ready : inst_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef RAM_ARB_RR_EN
        g_exp = '{32'h200, 32'h80, 32'h200, 32'h80};
`else
        g_exp = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
        repeat (2) @(negedge clk);
        check("rst_outs", {ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data}, 0);
        check("rst_rdy", {inst_ready, data_ready, stall_req}, 0);
        check("rst_rdata", {inst_rdata, data_rdata}, 0);
        rst = 1'b1;
        // fetch only, zero wait states
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h40; exp_inst.push_back(rword(32'h40));
        #1;
        check("f_stall_c0", stall_req, 1);
        check("f_en_c0", ram_en, 0);
        @(negedge clk);
        check("f_bus_c1", {ram_en, ram_write_en, ram_addr}, {1'b1, 1'b0, 32'h40});
        check("f_stall_c1", stall_req, 1);
        @(negedge clk);
        check("f_rdy_c2", inst_ready, 1);
        check("f_rdata_c2", inst_rdata, 32'h2402_0005);
        check("f_en_c2", ram_en, 0);
        check("f_stall_c2", stall_req, 0);
        inst_req = 1'b0;
        @(negedge clk);
        check("f_pulse", inst_ready, 0);
        // both requesters hold req through four grants
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200; inst_req = 1'b1; inst_addr = 32'h80;
        grants.delete();
        foreach (g_exp[i])
            if (g_exp[i] == 32'h200) exp_data.push_back(rword(32'h200));
            else exp_inst.push_back(rword(32'h80));
        last_drd = rword(32'h200);
        begin
            int got = 0;
            for (int i = 0; i < 60 && got < 4; i++) begin
                @(negedge clk);
                if (inst_ready || data_ready) got++;
            end
            check("stream_cnt", got, 4);
        end
        data_req = 1'b0; inst_req = 1'b0;
        check("stream_ngrant", grants.size(), 4);
        for (int i = 0; i < 4; i++) check("stream_order", i < grants.size() ? grants[i] : 32'hx, g_exp[i]);
        repeat (2) @(negedge clk);
        check("stream_idle", ram_en, 0);
        // byte write with three wait states
        data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0100; data_addr = 32'h100; data_wdata = 32'h5A5A_5A5A;
        ram_wait = 3; exp_data.push_back(last_drd);
        repeat (4) begin
            @(negedge clk);
            check("w_hold", {ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data},
                  {1'b1, 1'b1, 4'b0100, 32'h100, 32'h5A5A_5A5A});
        end
        @(negedge clk);
        check("w_rdy", {data_ready, inst_ready}, 2'b10);
        check("w_done_bus", {ram_en, ram_write_en, ram_write_sel, ram_addr, ram_write_data}, 0);
        check("w_rdata_kept", data_rdata, last_drd);
        data_req = 1'b0; data_we = 1'b0; data_sel = '0; ram_wait = 0;
        @(negedge clk);
        check("w_pulse", data_ready, 0);
        // data read with a fetch queued behind it
        data_req = 1'b1; data_addr = 32'h300; exp_data.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'h40; exp_inst.push_back(32'h2402_0005);
        check("q_data_bus", {ram_en, ram_addr}, {1'b1, 32'h300});
        @(negedge clk);
        check("q_data_rdy", {data_ready, inst_ready, data_rdata}, {2'b10, 32'hDEAD_BEEF});
        data_req = 1'b0; last_drd = 32'hDEAD_BEEF;
        @(negedge clk);
        check("q_gap", {ram_en, stall_req}, 2'b01);
        @(negedge clk);
        check("q_inst_bus", {ram_en, ram_addr}, {1'b1, 32'h40});
        @(negedge clk);
        check("q_inst_rdy", {inst_ready, data_ready}, 2'b10);
        inst_req = 1'b0;
        @(negedge clk);
        // write with no byte lanes still completes
        data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0000; data_addr = 32'h104; data_wdata = 32'h1234;
        exp_data.push_back(last_drd);
        wait_rdy(1'b1, 20, "z_rdy");
        check("z_rdata_kept", data_rdata, last_drd);
        data_req = 1'b0; data_we = 1'b0;
        @(negedge clk);
        // stray ram_ready in IDLE is ignored
        poke = 1'b1;
        repeat (2) @(negedge clk);
        check("pk_idle", {ram_en, inst_ready, data_ready}, 0);
        poke = 1'b0;
        // reset during a fetch abandons it
        ram_wait = 5; inst_req = 1'b1; inst_addr = 32'h44;
        @(negedge clk);
        check("r_en", ram_en, 1);
        #2 rst = 1'b0;
        #1;
        check("r_async_en", ram_en, 0);
        check("r_rdata_clr", {inst_rdata, data_rdata}, 0);
        repeat (2) @(negedge clk);
        check("r_no_rdy", inst_ready, 0);
        rst = 1'b1; exp_inst.push_back(rword(32'h44));
        wait_rdy(1'b0, 20, "r_reissue_rdy");
        check("r_reissue_rdata", inst_rdata, rword(32'h44));
        inst_req = 1'b0;
        @(negedge clk);
        check("sb_empty", exp_inst.size() + exp_data.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
